// File: rtl/chunked_adder_ctrl.sv
// rtl/chunked_adder_ctrl.sv - XLEN-bit add/subtract sequenced over a narrow ripple-carry adder
// Operands are consumed least-significant chunk first, one chunk per clock.

module ripple_carry_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[W];
    end
endmodule

module chunked_adder_ctrl #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] sum,
    output logic            carry_out,
    output logic            overflow
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   bop_q, bop_d;
    logic [XLEN-1:0]   sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk, add_s;
    logic              add_co;
    logic              last_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = bop_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_carry_adder #(.W(CHUNK)) u_rca (
        .a_i (a_chunk),
        .b_i (b_chunk),
        .c_i (carry_q),
        .s_o (add_s),
        .c_o (add_co)
    );

    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        bop_d   = bop_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    bop_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) sum_d[i*CHUNK +: CHUNK] = add_s;
                end
                carry_d = add_co;
                if (last_chunk) begin
                    // Top chunk holds the sign bits, so overflow is judged here.
                    cout_d  = add_co;
                    ovf_d   = (a_q[XLEN-1] == bop_q[XLEN-1]) && (add_s[CHUNK-1] != a_q[XLEN-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bop_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bop_q   <= bop_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: doc/chunked_adder_ctrl.md
Name: chunked_adder_ctrl

Overview:
- Sequencer that performs one XLEN-bit add or subtract by time-multiplexing a single CHUNK-bit ripple_carry_adder instance over XLEN/CHUNK cycles, least-significant chunk first.
- Accepts operands through a valid/ready handshake and returns sum, carry and signed overflow through a second valid/ready handshake.
- Sits between the ALU issue logic and a narrow adder; it trades latency for area on the wide add path.

Parameters:
- XLEN, 64, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, width of the internal ripple_carry_adder instance; 1 <= CHUNK <= XLEN.
- NCHUNK, XLEN/CHUNK, derived localparam, not overridable; counter width is clog2(NCHUNK), minimum 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- a  input  XLEN  first operand.
- b  input  XLEN  second operand.
- sub  input  1  1 = a - b, 0 = a + b.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  XLEN  result; meaningful only while out_valid = 1.
- carry_out  output  1  carry out of bit XLEN-1. For sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rstn low, async): state = IDLE, chunk index = 0, carry register = 0, sum = 0, carry_out = 0, overflow = 0, out_valid = 0, in_ready = 1. A reset in RUN or DONE aborts the operation with no out_valid pulse.
- States are IDLE, RUN and DONE. in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state.
- IDLE: on an edge with in_valid && in_ready, latch a and bop = sub ? ~b : b, set carry register = sub, set index = 0, go to RUN. With in_valid low, stay in IDLE.
- RUN: each edge
  - adds chunk [idx*CHUNK +: CHUNK] of a and bop with the carry register as carry_in;
  - writes the chunk result into sum[idx*CHUNK +: CHUNK];
  - loads carry register = adder carry_out;
  - increments idx.
  - On the edge that processes idx = NCHUNK-1, also register carry_out and overflow, and go to DONE.
- Overflow = (a[XLEN-1] == bop[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]), computed from the final chunk.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. For the defaults this is 4. For CHUNK == XLEN it is 1.
- DONE: sum, carry_out and overflow hold stable while out_ready = 0. On an edge with out_ready = 1, go to IDLE. The next operand is accepted no earlier than the following edge, so there is no same-cycle turnaround.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- The chunk index never wraps within an operation. It is reset to 0 on acceptance only.

Test Plan (XLEN=64, CHUNK=16):
- Reset, then a=0, b=0, sub=0 -> sum=0, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge, and in_ready = 0 throughout RUN and DONE.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0, carry_out=1, overflow=0. This proves the carry propagates across all 4 chunk boundaries.
- a=53, b=48, sub=1 -> sum=5, carry_out=1. Then a=48, b=53, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFB, carry_out=0, overflow=0.
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, carry_out=0, overflow=1.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid, sum and flags stay stable, in_ready=0 and the new request is ignored. On release, state is IDLE on the next cycle and in_ready=1.
- Assert rstn=0 asynchronously after 2 RUN cycles -> outputs go to reset values immediately and out_valid never pulses. The next operation (a=100, b=23, sub=0) returns sum=123.
